// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/control unit: state encoding and
// default widths, plus the $v0 service code the upstream decoder treats as halt.
package pipe_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned REG_W_DEF = 5;
  localparam int unsigned HALT_CODE = 10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/stat_counter.sv
// Free-running statistic counter with enable and synchronous clear; wraps modulo 2^W.
module stat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stage-control unit for the 5-stage MIPS pipe: load-use stalls,
// redirect flushes, halting-syscall freeze with resume, and run statistics.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             memtoreg_ex,
  input  logic             regwrite_ex,
  input  logic [REG_W-1:0] write_reg_ex,
  input  logic             redirect_ex,
  input  logic             halt_ex,
  input  logic             go,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t r_state;
  logic   r_halted;
  logic   r_resume;

  logic w_run;
  logic w_lu;
  logic w_halt_take;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_run = (r_state == ST_RUN);

  assign w_lu = memtoreg_ex & regwrite_ex & (write_reg_ex != '0) &
                ((use_rs_id & (rs_id == write_reg_ex)) | (use_rt_id & (rt_id == write_reg_ex)));

  // The first cycle after resume still sees the syscall in EX; ignore it there.
  assign w_halt_take = w_run & ~r_resume & halt_ex;
  assign w_flush_inc = w_run & ~w_halt_take & redirect_ex;
  assign w_stall_inc = w_run & ~w_halt_take & ~redirect_ex & w_lu;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
      r_resume <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          r_resume <= 1'b0;
          if (w_halt_take) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end
        end
        ST_HALT: begin
          if (go) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_resume <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
          r_resume <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if (w_run) begin
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (w_halt_take) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_en = 1'b0;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        id_ex_en = 1'b1;
        if (redirect_ex) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (w_lu) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
        if (r_resume) begin
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  assign halted = r_halted;

  stat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk (clk),
    .i_clr (clr),
    .i_en  (w_run),
    .o_cnt (cycle_cnt)
  );

  stat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk (clk),
    .i_clr (clr),
    .i_en  (w_stall_inc),
    .o_cnt (stall_cnt)
  );

  stat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk (clk),
    .i_clr (clr),
    .i_en  (w_flush_inc),
    .o_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a cycle-level reference model checked on every
// negedge, plus hand-computed literal expectations for each scenario.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  rs_id, rt_id, write_reg_ex;
  logic        use_rs_id, use_rt_id, memtoreg_ex, regwrite_ex, redirect_ex, halt_ex, go;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic        halted;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

  pipeline_ctrl #(.CNT_W(32), .REG_W(5)) dut (
    .clk          (clk),
    .clr          (clr),
    .rs_id        (rs_id),
    .rt_id        (rt_id),
    .use_rs_id    (use_rs_id),
    .use_rt_id    (use_rt_id),
    .memtoreg_ex  (memtoreg_ex),
    .regwrite_ex  (regwrite_ex),
    .write_reg_ex (write_reg_ex),
    .redirect_ex  (redirect_ex),
    .halt_ex      (halt_ex),
    .go           (go),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_en     (id_ex_en),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .halted       (halted),
    .cycle_cnt    (cycle_cnt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit          m_valid = 1'b0;
  bit          m_halt, m_res;
  logic [31:0] m_cyc, m_stall, m_flush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_lu();
    return memtoreg_ex && regwrite_ex && write_reg_ex != 0 &&
           ((use_rs_id && rs_id == write_reg_ex) || (use_rt_id && rt_id == write_reg_ex));
  endfunction

  // Expected {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  function automatic logic [6:0] model_ctl();
    logic [6:0] v;
    if (m_halt) return 7'b0000000;
    if (halt_ex && !m_res) return 7'b0000011;
    v = 7'b1101011;
    if (redirect_ex) v = 7'b1111111;
    else if (model_lu()) v = 7'b0001111;
    if (m_res) v[2:1] = 2'b11;
    return v;
  endfunction

  task automatic model_edge();
    if (clr) begin
      m_valid = 1'b1;
      m_halt  = 1'b0;
      m_res   = 1'b0;
      m_cyc   = 0;
      m_stall = 0;
      m_flush = 0;
    end else if (!m_halt) begin
      m_cyc++;
      if (halt_ex && !m_res) m_halt = 1'b1;
      else if (redirect_ex) m_flush++;
      else if (model_lu()) m_stall++;
      m_res = 1'b0;
    end else if (go) begin
      m_halt = 1'b0;
      m_res  = 1'b1;
    end
  endtask

  // Compare at negedge, advance model at posedge, return 1 time unit later.
  task automatic tick();
    @(negedge clk);
    if (m_valid) begin
      chk("ctl", {25'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
                  mem_wb_en}, {25'd0, model_ctl()});
      chk("halted", {31'd0, halted}, {31'd0, m_halt});
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    clr = 0; rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0; memtoreg_ex = 0;
    regwrite_ex = 0; write_reg_ex = 0; redirect_ex = 0; halt_ex = 0; go = 0;
  endtask

  task automatic do_reset();
    idle_in();
    clr = 1;
    tick();
    clr = 0;
  endtask

  // Directed vectors: {rs, rt, use_rs, use_rt, memtoreg, regwrite, wr, redirect, go}
  typedef struct packed {
    logic [4:0] rs, rt;
    logic       urs, urt, mtr, rw;
    logic [4:0] wr;
    logic       rd, g;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{rs: 5'd3, rt: 5'd9, urs: 1, urt: 1, mtr: 1, rw: 1, wr: 5'd9, rd: 0, g: 0};
    vecs[1] = '{rs: 5'd3, rt: 5'd9, urs: 1, urt: 0, mtr: 1, rw: 1, wr: 5'd9, rd: 0, g: 0};
    vecs[2] = '{rs: 5'd4, rt: 5'd1, urs: 1, urt: 1, mtr: 1, rw: 0, wr: 5'd4, rd: 0, g: 0};
    vecs[3] = '{rs: 5'd4, rt: 5'd1, urs: 1, urt: 1, mtr: 0, rw: 1, wr: 5'd4, rd: 0, g: 0};
    vecs[4] = '{rs: 5'd7, rt: 5'd2, urs: 1, urt: 1, mtr: 1, rw: 1, wr: 5'd5, rd: 0, g: 0};
    vecs[5] = '{rs: 5'd0, rt: 5'd0, urs: 0, urt: 0, mtr: 0, rw: 0, wr: 5'd0, rd: 1, g: 0};
    vecs[6] = '{rs: 5'd0, rt: 5'd0, urs: 0, urt: 0, mtr: 0, rw: 0, wr: 5'd0, rd: 0, g: 1};
    vecs[7] = '{rs: 5'd31, rt: 5'd0, urs: 1, urt: 0, mtr: 1, rw: 1, wr: 5'd31, rd: 0, g: 0};

    // 1: reset then 5 idle cycles
    do_reset();
    repeat (5) tick();
    chk("t1 cycle_cnt", cycle_cnt, 32'd5);
    chk("t1 stall_cnt", stall_cnt, 32'd0);
    chk("t1 halted", {31'd0, halted}, 32'd0);
    chk("t1 pc_en", {31'd0, pc_en}, 32'd1);

    // 2: load-use on rs, then the same with write_reg_ex=0
    memtoreg_ex = 1; regwrite_ex = 1; write_reg_ex = 8; rs_id = 8; use_rs_id = 1;
    #1;
    chk("t2 pc_en", {31'd0, pc_en}, 32'd0);
    chk("t2 if_id_en", {31'd0, if_id_en}, 32'd0);
    chk("t2 id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    chk("t2 ex_mem_en", {31'd0, ex_mem_en}, 32'd1);
    tick();
    chk("t2 stall_cnt", stall_cnt, 32'd1);
    write_reg_ex = 0; rs_id = 0;
    #1;
    chk("t2 r0 pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    chk("t2 r0 stall_cnt", stall_cnt, 32'd1);

    // 3: load-use plus redirect; redirect wins, stall count unchanged
    do_reset();
    memtoreg_ex = 1; regwrite_ex = 1; write_reg_ex = 8; rs_id = 8; use_rs_id = 1;
    redirect_ex = 1;
    #1;
    chk("t3 if_id_flush", {31'd0, if_id_flush}, 32'd1);
    chk("t3 id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    chk("t3 pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    chk("t3 flush_cnt", flush_cnt, 32'd1);
    chk("t3 stall_cnt", stall_cnt, 32'd0);
    idle_in();

    // Extra directed vectors through the model
    for (int i = 0; i < 8; i++) begin
      rs_id = vecs[i].rs; rt_id = vecs[i].rt; use_rs_id = vecs[i].urs; use_rt_id = vecs[i].urt;
      memtoreg_ex = vecs[i].mtr; regwrite_ex = vecs[i].rw; write_reg_ex = vecs[i].wr;
      redirect_ex = vecs[i].rd; go = vecs[i].g;
      tick();
    end
    idle_in();
    // vecs 0 and 7 stall, vec 5 flushes
    chk("vec stall_cnt", stall_cnt, 32'd2);
    chk("vec flush_cnt", flush_cnt, 32'd2);

    // 4: halt in the 10th RUN cycle
    do_reset();
    repeat (9) tick();
    halt_ex = 1;
    #1;
    chk("t4 pc_en", {31'd0, pc_en}, 32'd0);
    chk("t4 id_ex_en", {31'd0, id_ex_en}, 32'd0);
    chk("t4 ex_mem_en", {31'd0, ex_mem_en}, 32'd1);
    tick();
    chk("t4 halted", {31'd0, halted}, 32'd1);
    repeat (20) tick();
    chk("t4 cycle_cnt", cycle_cnt, 32'd10);
    chk("t4 mem_wb_en", {31'd0, mem_wb_en}, 32'd0);

    // 5: resume with the syscall still in EX
    go = 1;
    #1;
    chk("t5 go-cycle halted", {31'd0, halted}, 32'd1);
    chk("t5 go-cycle ex_mem_en", {31'd0, ex_mem_en}, 32'd0);
    tick();
    go = 0;
    #1;
    chk("t5 halted", {31'd0, halted}, 32'd0);
    chk("t5 id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    chk("t5 id_ex_en", {31'd0, id_ex_en}, 32'd1);
    chk("t5 pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    halt_ex = 0;
    #1;
    chk("t5 no re-halt", {31'd0, halted}, 32'd0);
    chk("t5 id_ex_flush after", {31'd0, id_ex_flush}, 32'd0);
    chk("t5 cycle_cnt", cycle_cnt, 32'd11);
    tick();

    // 6: clr while halted with nonzero counters
    memtoreg_ex = 1; regwrite_ex = 1; write_reg_ex = 3; rt_id = 3; use_rt_id = 1;
    tick();
    idle_in();
    halt_ex = 1;
    tick();
    halt_ex = 0;
    repeat (2) tick();
    chk("t6 pre halted", {31'd0, halted}, 32'd1);
    chk("t6 pre stall_cnt", stall_cnt, 32'd1);
    clr = 1;
    tick();
    clr = 0;
    #1;
    chk("t6 halted", {31'd0, halted}, 32'd0);
    chk("t6 cycle_cnt", cycle_cnt, 32'd0);
    chk("t6 stall_cnt", stall_cnt, 32'd0);
    chk("t6 pc_en", {31'd0, pc_en}, 32'd1);
    chk("t6 id_ex_flush", {31'd0, id_ex_flush}, 32'd0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
